// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage in-order core: load-use stall,
// taken-branch flush, LSU freeze, EX operand forwarding and two hazard counters.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_use_rs1_i,
  input  logic              id_is_rs2_i,
  input  logic              id_rd_wren_i,
  input  logic              id_is_load_i,
  input  logic              ex_br_taken_i,
  input  logic              mem_busy_i,
  output logic              stall_pc_o,
  output logic              stall_if_id_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              stall_ex_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [CNT_W-1:0]  ld_stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              ex_use_rs1, ex_is_rs2, ex_wren, ex_is_load;
  logic              mem_wren, mem_is_load, wb_wren;
  logic              lu, ld_inc, fl_inc, ex_bubble;

  // Load in EX whose destination the ID instruction actually reads.
  assign lu = ex_is_load && ex_wren && (ex_rd != '0) &&
              ((id_use_rs1_i && (ex_rd == id_rs1_i)) ||
               (id_is_rs2_i  && (ex_rd == id_rs2_i)));

  assign fl_inc    = !mem_busy_i && ex_br_taken_i;
  assign ld_inc    = !mem_busy_i && !ex_br_taken_i && lu;
  assign ex_bubble = ex_br_taken_i || lu;

  always_comb begin
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    stall_ex_o    = 1'b0;
    if (mem_busy_i) begin
      stall_pc_o    = 1'b1;
      stall_if_id_o = 1'b1;
      stall_ex_o    = 1'b1;
    end else if (ex_br_taken_i) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (lu) begin
      stall_pc_o    = 1'b1;
      stall_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  // MEM beats WB; loads in MEM have no data yet, and x0 is never forwarded.
  always_comb begin
    fwd_a_sel_o = 2'b00;
    fwd_b_sel_o = 2'b00;
    if (ex_use_rs1 && mem_wren && !mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs1))
      fwd_a_sel_o = 2'b01;
    else if (ex_use_rs1 && wb_wren && (wb_rd != '0) && (wb_rd == ex_rs1))
      fwd_a_sel_o = 2'b10;
    if (ex_is_rs2 && mem_wren && !mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs2))
      fwd_b_sel_o = 2'b01;
    else if (ex_is_rs2 && wb_wren && (wb_rd != '0) && (wb_rd == ex_rs2))
      fwd_b_sel_o = 2'b10;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_use_rs1  <= 1'b0;
      ex_is_rs2   <= 1'b0;
      ex_wren     <= 1'b0;
      ex_is_load  <= 1'b0;
      mem_rd      <= '0;
      mem_wren    <= 1'b0;
      mem_is_load <= 1'b0;
      wb_rd       <= '0;
      wb_wren     <= 1'b0;
    end else if (!mem_busy_i) begin
      wb_rd       <= mem_rd;
      wb_wren     <= mem_wren;
      mem_rd      <= ex_rd;
      mem_wren    <= ex_wren;
      mem_is_load <= ex_is_load;
      if (ex_bubble) begin
        ex_rs1     <= '0;
        ex_rs2     <= '0;
        ex_rd      <= '0;
        ex_use_rs1 <= 1'b0;
        ex_is_rs2  <= 1'b0;
        ex_wren    <= 1'b0;
        ex_is_load <= 1'b0;
      end else begin
        ex_rs1     <= id_rs1_i;
        ex_rs2     <= id_rs2_i;
        ex_rd      <= id_rd_i;
        ex_use_rs1 <= id_use_rs1_i;
        ex_is_rs2  <= id_is_rs2_i;
        ex_wren    <= id_rd_wren_i;
        ex_is_load <= id_is_load_i;
      end
    end
  end

  // Saturating counters: they stop at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_stall_cnt_o <= '0;
      flush_cnt_o    <= '0;
    end else begin
      if (ld_inc && (ld_stall_cnt_o != '1)) ld_stall_cnt_o <= ld_stall_cnt_o + CNT_ONE;
      if (fl_inc && (flush_cnt_o != '1))    flush_cnt_o    <= flush_cnt_o + CNT_ONE;
    end
  end

endmodule
